// File: rtl/sd_seq_pkg.sv
// Shared types and constants for the SD read sequencer.
package sd_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_CHECK,
    S_RETRY,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_TIMEOUT,
    ERR_NOFILE,
    ERR_BADFS
  } err_t;

  localparam logic [2:0] FAT_DONE = 3'd6;
  localparam logic [1:0] FS_INVALID = 2'd1;

  // Reflected form of polynomial 0x04C11DB7
  localparam logic [31:0] CRC_POLY_R = 32'hEDB8_8320;

  function automatic logic [31:0] crc32_step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sd_seq_crc32.sv
// Byte-wide CRC-32 accumulator; output is the final-xored value.
module sd_seq_crc32
  import sd_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] acc;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= 32'hFFFF_FFFF;
    end else if (en) begin
      acc <= crc32_step(acc, data);
    end
  end

  // Reset preload inverts to zero, matching the idle crc32 value
  assign crc = ~acc;

endmodule

// File: rtl/sd_read_sequencer.sv
// Run-control for the SD file reader: reset hold, retry, status, byte forwarding.
// Optional CRC-32 of forwarded bytes when SD_SEQ_CRC32_EN is defined.
module sd_read_sequencer
  import sd_seq_pkg::*;
#(
  parameter int RESET_HOLD     = 16,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int MAX_RETRY      = 3,
  parameter int BYTE_CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  reader_rst_n,
  input  logic [2:0]            fatstate,
  input  logic [1:0]            filesystemtype,
  input  logic                  file_found,
  input  logic                  outreq,
  input  logic [7:0]            outbyte,
  output logic                  byte_valid,
  output logic [7:0]            byte_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [2:0]            retry_cnt,
  output logic [BYTE_CNT_W-1:0] byte_count,
  output logic [31:0]           crc32
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(RESET_HOLD);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(RESET_HOLD - 1);
  localparam logic [2:0] R_MAX = 3'(MAX_RETRY);

  state_t        state;
  state_t        nxt;
  err_t          nerr;
  logic [TW-1:0] timer;
  logic [HW-1:0] hold_cnt;
  logic          act;
  logic          go;
  logic          halt;
  logic          fwd;
  logic          retry_ok;
  logic          restart;

  assign act = state inside {S_HOLD, S_RUN, S_CHECK, S_RETRY};
  assign go = start && !act;
  assign halt = abort && act;
  assign fwd = (state == S_RUN) && outreq;
  assign retry_ok = retry_cnt < R_MAX;
  assign restart = go || ((state == S_RETRY) && retry_ok && !halt);

  always_comb begin
    nxt = state;
    nerr = ERR_NONE;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) nxt = S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt == H_LAST) nxt = S_RUN;
      end
      S_RUN: begin
        if (fatstate == FAT_DONE) begin
          nxt = S_CHECK;
        end else if (filesystemtype == FS_INVALID) begin
          nxt = S_ERROR;
          nerr = ERR_BADFS;
        end else if (!outreq && timer == T_LAST) begin
          nxt = S_RETRY;
        end
      end
      S_CHECK: begin
        if (file_found) begin
          nxt = S_DONE;
        end else begin
          nxt = S_ERROR;
          nerr = ERR_NOFILE;
        end
      end
      S_RETRY: begin
        if (retry_ok) begin
          nxt = S_HOLD;
        end else begin
          nxt = S_ERROR;
          nerr = ERR_TIMEOUT;
        end
      end
      default: nxt = S_IDLE;
    endcase
    if (halt) nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      reader_rst_n <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= '0;
      retry_cnt    <= '0;
      byte_count   <= '0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      timer        <= '0;
      hold_cnt     <= '0;
    end else begin
      state        <= nxt;
      reader_rst_n <= nxt inside {S_RUN, S_CHECK, S_RETRY, S_DONE};
      busy         <= nxt inside {S_HOLD, S_RUN, S_CHECK, S_RETRY};
      hold_cnt     <= (state == S_HOLD && nxt == S_HOLD)
                      ? hold_cnt + 1'b1 : '0;
      // Timer only runs while staying in RUN without a byte
      timer        <= (state == S_RUN && nxt == S_RUN && !outreq)
                      ? timer + 1'b1 : '0;
      byte_valid   <= fwd;
      if (fwd) byte_data <= outbyte;
      if (go) begin
        done       <= 1'b0;
        error      <= 1'b0;
        err_code   <= '0;
        retry_cnt  <= '0;
        byte_count <= '0;
      end else if (restart) begin
        retry_cnt  <= retry_cnt + 3'd1;
        byte_count <= '0;
      end else if (fwd) begin
        byte_count <= byte_count + 1'b1;
      end
      if (nxt == S_DONE) done <= 1'b1;
      if (nxt == S_ERROR && state != S_ERROR) begin
        error    <= 1'b1;
        err_code <= nerr;
      end
    end
  end

`ifdef SD_SEQ_CRC32_EN
  sd_seq_crc32 u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (restart),
    .en   (byte_valid),
    .data (byte_data),
    .crc  (crc32)
  );
`else
  assign crc32 = 32'd0;
`endif

endmodule

// File: tb/tb_sd_read_sequencer.sv
// Self-checking bench for sd_read_sequencer with a simple reader model.
module tb_sd_read_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        reader_rst_n;
  logic [2:0]  fatstate;
  logic [1:0]  filesystemtype;
  logic        file_found;
  logic        outreq;
  logic [7:0]  outbyte;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [2:0]  retry_cnt;
  logic [31:0] byte_count;
  logic [31:0] crc32;

  sd_read_sequencer #(
    .RESET_HOLD     (4),
    .TIMEOUT_CYCLES (100),
    .MAX_RETRY      (2),
    .BYTE_CNT_W     (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .reader_rst_n   (reader_rst_n),
    .fatstate       (fatstate),
    .filesystemtype (filesystemtype),
    .file_found     (file_found),
    .outreq         (outreq),
    .outbyte        (outbyte),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_code       (err_code),
    .retry_cnt      (retry_cnt),
    .byte_count     (byte_count),
    .crc32          (crc32)
  );

  always #10 clk = ~clk;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int         nbytes;
    logic [2:0] fat;
    logic [1:0] fs;
    logic       found;
    logic       exp_done;
    logic       exp_err;
    logic [1:0] exp_code;
    int         exp_lat;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (byte_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("byte_unexpected", 64'(byte_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("byte_data", 64'(byte_data), 64'(e.data));
        chk("byte_latency", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic expect_fwd);
    outreq = 1'b1;
    outbyte = b;
    if (expect_fwd) sb.push_back('{b, cyc + 1});
    step();
    outreq = 1'b0;
    step();
  endtask

  task automatic count_hold(input string nm);
    int low = 0;
    while (reader_rst_n !== 1'b1 && low < 50) begin
      low++;
      step();
    end
    chk(nm, 64'(low), 64'd4);
  endtask

  task automatic wait_end(input string nm, input int max, output int n);
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < max) begin
      step();
      n++;
    end
    chk(nm, 64'(done | error), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int low;
    int pulses;

    tbl[0] = '{5, 3'd6, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2};
    tbl[1] = '{3, 3'd6, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2, 2};
    tbl[2] = '{2, 3'd0, 2'd1, 1'b0, 1'b0, 1'b1, 2'd3, 1};
    tbl[3] = '{0, 3'd6, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0, 2};
    tbl[4] = '{1, 3'd6, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 2};

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    fatstate = '0;
    filesystemtype = '0;
    file_found = 1'b0;
    outreq = 1'b0;
    outbyte = '0;
    repeat (3) step();

    chk("rst_reader_rst_n", 64'(reader_rst_n), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done_error", 64'({done, error}), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_retry_cnt", 64'(retry_cnt), 64'd0);
    chk("rst_byte_count", 64'(byte_count), 64'd0);
    chk("rst_byte_out", 64'({byte_valid, byte_data}), 64'd0);
    chk("rst_crc32", 64'(crc32), 64'd0);

    rst = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("idle_abort_ignored", 64'({busy, reader_rst_n}), 64'd0);

    for (int i = 0; i < 5; i++) begin
      pulse_start();
      chk("start_clears", 64'({done, error, err_code}), 64'd0);
      chk("start_busy", 64'(busy), 64'd1);
      count_hold("hold_len");
      for (int b = 0; b < tbl[i].nbytes; b++) begin
        send_byte(8'h41 + 8'(b), 1'b1);
      end
      fatstate = tbl[i].fat;
      filesystemtype = tbl[i].fs;
      file_found = tbl[i].found;
      wait_end("vec_end_reached", 10, n);
      chk("vec_latency", 64'(n), 64'(tbl[i].exp_lat));
      chk("vec_done", 64'(done), 64'(tbl[i].exp_done));
      chk("vec_error", 64'(error), 64'(tbl[i].exp_err));
      chk("vec_err_code", 64'(err_code), 64'(tbl[i].exp_code));
      chk("vec_byte_count", 64'(byte_count), 64'(tbl[i].nbytes));
      chk("vec_retry_cnt", 64'(retry_cnt), 64'd0);
      chk("vec_busy", 64'(busy), 64'd0);
      chk("vec_reader_rst_n", 64'(reader_rst_n), 64'(tbl[i].exp_done));
`ifdef SD_SEQ_CRC32_EN
      if (i == 0) chk("crc_abcde", 64'(crc32), 64'h72D3_1AD5);
`else
      chk("crc_tied_zero", 64'(crc32), 64'd0);
`endif
      fatstate = '0;
      filesystemtype = '0;
      file_found = 1'b0;
      step();
    end

    // outreq while DONE must be dropped
    outreq = 1'b1;
    outbyte = 8'h99;
    step();
    chk("done_outreq_valid", 64'(byte_valid), 64'd0);
    step();
    step();
    outreq = 1'b0;
    step();
    chk("done_outreq_count", 64'(byte_count), 64'd1);
    chk("done_level", 64'(done), 64'd1);

    // Reader never responds: three attempts then timeout error
    pulse_start();
    pulses = 0;
    low = 0;
    n = 0;
    while (error !== 1'b1 && n < 1000) begin
      if (reader_rst_n === 1'b0) begin
        low++;
      end else if (low > 0) begin
        chk("retry_hold_len", 64'(low), 64'd4);
        chk("retry_cnt_attempt", 64'(retry_cnt), 64'(pulses));
        pulses++;
        low = 0;
      end
      step();
      n++;
    end
    chk("timeout_error", 64'(error), 64'd1);
    chk("timeout_attempts", 64'(pulses), 64'd3);
    chk("timeout_err_code", 64'(err_code), 64'd1);
    chk("timeout_retry_cnt", 64'(retry_cnt), 64'd2);
    chk("timeout_idle", 64'({busy, reader_rst_n, done}), 64'd0);

    // Abort and start together during RUN
    pulse_start();
    count_hold("hold_len_abort");
    send_byte(8'h5A, 1'b1);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_reader_rst_n", 64'(reader_rst_n), 64'd0);
    chk("abort_keeps_count", 64'(byte_count), 64'd1);
    chk("abort_status", 64'({done, error}), 64'd0);

    // outreq while IDLE must be dropped
    outreq = 1'b1;
    outbyte = 8'h11;
    step();
    chk("idle_outreq_valid", 64'(byte_valid), 64'd0);
    step();
    outreq = 1'b0;
    step();
    chk("idle_outreq_count", 64'(byte_count), 64'd1);

    pulse_start();
    chk("restart_busy", 64'(busy), 64'd1);
    chk("restart_count", 64'(byte_count), 64'd0);
    count_hold("hold_len_restart");

    // start while busy is ignored
    pulse_start();
    chk("busy_start_busy", 64'(busy), 64'd1);
    chk("busy_start_rst_n", 64'(reader_rst_n), 64'd1);
    send_byte(8'h77, 1'b1);
    chk("busy_start_count", 64'(byte_count), 64'd1);

    // Reset in RUN with a byte strobe present
    outreq = 1'b1;
    outbyte = 8'hEE;
    rst = 1'b1;
    step();
    rst = 1'b0;
    outreq = 1'b0;
    chk("midrst_reader_rst_n", 64'(reader_rst_n), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_status", 64'({done, error, err_code, retry_cnt}), 64'd0);
    chk("midrst_count", 64'(byte_count), 64'd0);
    chk("midrst_byte", 64'({byte_valid, byte_data}), 64'd0);
    chk("midrst_crc32", 64'(crc32), 64'd0);
    step();
    chk("midrst_dropped", 64'({byte_valid, busy}), 64'd0);

    step();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
